// File: rtl/adder_defs.sv
// Shared definitions for the time-shared nibble adder.
//   NIBBLE_W : width of the shared ripple adder slice
//   ID_W     : width of the requester identifier
//   state_t  : scheduler state codes (code 3 is illegal and recovers to IDLE)
package adder_defs;

   localparam int NIBBLE_W = 4;
   localparam int ID_W     = 1;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage

// File: rtl/full_adder.sv
// One-bit full-adder cell, the building block of the shared ripple adder.
//   a, b, cin : input bits
//   sum, cout : sum bit and carry out
module full_adder (
   input  logic a,
   input  logic b,
   input  logic cin,
   output logic sum,
   output logic cout
);

   assign sum  = a ^ b ^ cin;
   assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/nibble_add.sv
// Combinational 4-bit ripple-carry adder built from a chain of full adders.
//   a, b : 4-bit operand nibbles
//   cin  : carry into bit 0
//   sum  : 4-bit sum nibble
//   cout : carry out of bit 3
module nibble_add
   import adder_defs::*;
(
   input  logic [NIBBLE_W-1:0] a,
   input  logic [NIBBLE_W-1:0] b,
   input  logic                cin,
   output logic [NIBBLE_W-1:0] sum,
   output logic                cout
);

   logic [NIBBLE_W:0] carry;

   assign carry[0] = cin;

   for (genvar gi = 0; gi < NIBBLE_W; gi++) begin : g_bit
      full_adder u_fa (
         .a    (a[gi]),
         .b    (b[gi]),
         .cin  (carry[gi]),
         .sum  (sum[gi]),
         .cout (carry[gi+1])
      );
   end

   assign cout = carry[NIBBLE_W];

endmodule

// File: rtl/nibble_add_sched.sv
// Round-robin scheduler that time-shares one 4-bit adder between two
// requesters. A granted operation is added one nibble per cycle, LSB first,
// with the carry held in a register; the result is then offered on a
// valid/ready response port.
//   clk, rst              : clock, synchronous active-high reset
//   reqN_valid/ready      : request handshake for requester N (0/1)
//   reqN_a, reqN_b, cin   : operands and carry-in for requester N
//   rsp_valid/ready       : response handshake
//   rsp_id                : requester that owns the result
//   rsp_sum, rsp_cout     : (A + B + cin) mod 2^W and carry out of top nibble
//   busy                  : scheduler is not idle
module nibble_add_sched
   import adder_defs::*;
#(
   parameter int NIBBLES = 4
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         req0_valid,
   output logic                         req0_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0]  req0_a,
   input  logic [NIBBLE_W*NIBBLES-1:0]  req0_b,
   input  logic                         req0_cin,
   input  logic                         req1_valid,
   output logic                         req1_ready,
   input  logic [NIBBLE_W*NIBBLES-1:0]  req1_a,
   input  logic [NIBBLE_W*NIBBLES-1:0]  req1_b,
   input  logic                         req1_cin,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic                         rsp_id,
   output logic [NIBBLE_W*NIBBLES-1:0]  rsp_sum,
   output logic                         rsp_cout,
   output logic                         busy
);

   localparam int W     = NIBBLE_W * NIBBLES;
   localparam int CNT_W = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
   localparam logic [CNT_W-1:0] LAST_NIB = CNT_W'(NIBBLES - 1);

   state_t            state_reg;
   logic [ID_W-1:0]   prio_reg;
   logic [CNT_W-1:0]  cnt_reg;
   logic              carry_reg;
   logic [W-1:0]      a_reg;
   logic [W-1:0]      b_reg;
   logic [ID_W-1:0]   id_reg;
   // Partial sums build up here so the visible result never shows a
   // half-finished operation.
   logic [W-1:0]      work_reg;
   logic [W-1:0]      sum_reg;
   logic              cout_reg;
   logic [ID_W-1:0]   rsp_id_reg;

   logic              grant_any;
   logic [ID_W-1:0]   grant_id;
   logic [NIBBLE_W-1:0] a_nib;
   logic [NIBBLE_W-1:0] b_nib;
   logic [NIBBLE_W-1:0] nib_sum;
   logic                nib_cout;
   logic [NIBBLES-1:0]  nib_sel;
   logic [W-1:0]        work_next;

   // Arbitration is only live in IDLE; a lone requester wins outright and a
   // tie goes to the round-robin pointer.
   always_comb begin
      grant_any = 1'b0;
      grant_id  = '0;
      if (state_reg == ST_IDLE) begin
         if (req0_valid && req1_valid) begin
            grant_any = 1'b1;
            grant_id  = prio_reg;
         end else if (req0_valid) begin
            grant_any = 1'b1;
            grant_id  = '0;
         end else if (req1_valid) begin
            grant_any = 1'b1;
            grant_id  = '1;
         end
      end
   end

   assign req0_ready = grant_any && (grant_id == '0);
   assign req1_ready = grant_any && (grant_id == '1);

   // Nibble select: shift by cnt*4 and keep the low nibble.
   assign a_nib = NIBBLE_W'(a_reg >> {cnt_reg, 2'b00});
   assign b_nib = NIBBLE_W'(b_reg >> {cnt_reg, 2'b00});

   nibble_add u_add (
      .a    (a_nib),
      .b    (b_nib),
      .cin  (carry_reg),
      .sum  (nib_sum),
      .cout (nib_cout)
   );

   // Result demux: only the slice addressed by the counter takes the new nibble.
   for (genvar gi = 0; gi < NIBBLES; gi++) begin : g_demux
      assign nib_sel[gi] = (cnt_reg == CNT_W'(gi));
      assign work_next[NIBBLE_W*gi +: NIBBLE_W] =
         nib_sel[gi] ? nib_sum : work_reg[NIBBLE_W*gi +: NIBBLE_W];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg  <= ST_IDLE;
         prio_reg   <= '0;
         cnt_reg    <= '0;
         carry_reg  <= 1'b0;
         a_reg      <= '0;
         b_reg      <= '0;
         id_reg     <= '0;
         work_reg   <= '0;
         sum_reg    <= '0;
         cout_reg   <= 1'b0;
         rsp_id_reg <= '0;
      end else begin
         case (state_reg)
            ST_IDLE: begin
               if (grant_any) begin
                  a_reg     <= (grant_id == '1) ? req1_a : req0_a;
                  b_reg     <= (grant_id == '1) ? req1_b : req0_b;
                  carry_reg <= (grant_id == '1) ? req1_cin : req0_cin;
                  id_reg    <= grant_id;
                  cnt_reg   <= '0;
                  prio_reg  <= ~grant_id;
                  state_reg <= ST_RUN;
               end
            end
            ST_RUN: begin
               work_reg  <= work_next;
               carry_reg <= nib_cout;
               cnt_reg   <= cnt_reg + CNT_W'(1);
               if (cnt_reg == LAST_NIB) begin
                  sum_reg    <= work_next;
                  cout_reg   <= nib_cout;
                  rsp_id_reg <= id_reg;
                  state_reg  <= ST_DONE;
               end
            end
            ST_DONE: begin
               if (rsp_ready) begin
                  state_reg <= ST_IDLE;
               end
            end
            default: begin
               state_reg <= ST_IDLE;
            end
         endcase
      end
   end

   assign rsp_valid = (state_reg == ST_DONE);
   assign busy      = (state_reg != ST_IDLE);
   assign rsp_id    = rsp_id_reg;
   assign rsp_sum   = sum_reg;
   assign rsp_cout  = cout_reg;

endmodule
